// File: rtl/traffic_phase_controller_if.sv
// traffic_phase_controller_if: sensor/flash inputs and lamp/status outputs of the phase controller
interface traffic_phase_controller_if #(
    parameter int NUM_PHASES = 4
);
    localparam int AW = $clog2(NUM_PHASES);
    logic [NUM_PHASES-1:0] req;
    logic                  flash_en;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] red;
    logic [AW-1:0]         active_phase;
    logic                  flashing;
    modport master (output req, flash_en, input green, yellow, red, active_phase, flashing);
    modport slave  (input req, flash_en, output green, yellow, red, active_phase, flashing);
endinterface

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: round-robin signal phase FSM with min/max green, yellow, all-red and flash mode
module traffic_phase_controller #(
    parameter int NUM_PHASES = 4,
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 20,
    parameter int YELLOW_T   = 4,
    parameter int ALLRED_T   = 2,
    parameter int FLASH_HALF = 10
) (
    input logic clk,
    input logic reset_n,
    traffic_phase_controller_if.slave bus
);
    localparam int AW   = $clog2(NUM_PHASES);
    localparam int T1   = GREEN_MAX > YELLOW_T ? GREEN_MAX : YELLOW_T;
    localparam int T2   = ALLRED_T > FLASH_HALF ? ALLRED_T : FLASH_HALF;
    localparam int TMAX = T1 > T2 ? T1 : T2;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] GMIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YEND = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AEND = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] FEND = TW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED, FLASH} state_t;

    state_t                state, state_nx;
    logic [TW-1:0]         timer, timer_nx;
    logic [AW-1:0]         active, active_nx, rr_next, rr_idx;
    logic [NUM_PHASES-1:0] pend, pend_nx, onehot;
    logic                  lit, lit_nx, from_flash, from_flash_nx, other_pend;

    assign onehot     = NUM_PHASES'(1) << active;
    assign other_pend = |(pend & ~onehot);

    // Descending scan so the nearest pending phase after active wins; none pending leaves phase 0
    always_comb begin
        rr_next = '0;
        rr_idx  = '0;
        for (int k = NUM_PHASES; k >= 1; k--) begin
            rr_idx = AW'((int'(active) + k) % NUM_PHASES);
            if (pend[rr_idx]) rr_next = rr_idx;
        end
    end

    always_comb begin
        state_nx      = state;
        timer_nx      = timer + 1'b1;
        active_nx     = active;
        pend_nx       = pend;
        lit_nx        = lit;
        from_flash_nx = from_flash;
        for (int i = 0; i < NUM_PHASES; i++)
            if (bus.req[i] && !(state == GREEN && active == AW'(i))) pend_nx[i] = 1'b1;
        case (state)
            GREEN: begin
                if (bus.flash_en || (other_pend && ((timer >= GMIN && !bus.req[active]) || timer == GMAX))) begin
                    state_nx = YELLOW;
                    timer_nx = '0;
                end else if (timer == GMAX) begin
                    timer_nx = timer;
                end
            end
            YELLOW: begin
                if (timer == YEND) begin
                    state_nx      = ALL_RED;
                    timer_nx      = '0;
                    from_flash_nx = 1'b0;
                end
            end
            ALL_RED: begin
                if (timer == AEND) begin
                    timer_nx = '0;
                    if (bus.flash_en) begin
                        state_nx  = FLASH;
                        active_nx = '0;
                        lit_nx    = 1'b1;
                    end else begin
                        state_nx           = GREEN;
                        active_nx          = from_flash ? '0 : rr_next;
                        pend_nx[active_nx] = 1'b0;
                    end
                end
            end
            FLASH: begin
                if (!bus.flash_en) begin
                    state_nx      = ALL_RED;
                    timer_nx      = '0;
                    from_flash_nx = 1'b1;
                end else if (timer == FEND) begin
                    timer_nx = '0;
                    lit_nx   = ~lit;
                end
            end
            default: state_nx = GREEN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= GREEN;
            timer      <= '0;
            active     <= '0;
            pend       <= '0;
            lit        <= 1'b0;
            from_flash <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            active     <= active_nx;
            pend       <= pend_nx;
            lit        <= lit_nx;
            from_flash <= from_flash_nx;
        end
    end

    assign bus.green        = state == GREEN ? onehot : '0;
    assign bus.yellow       = state == FLASH ? (lit ? NUM_PHASES'(1) : '0) : (state == YELLOW ? onehot : '0);
    assign bus.red          = state == FLASH ? (lit ? ~NUM_PHASES'(1) : '0)
                                             : ~((state == GREEN || state == YELLOW) ? onehot : '0);
    assign bus.active_phase = active;
    assign bus.flashing     = state == FLASH;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: scoreboard bench; expected lamp snapshots are queued per scenario and popped each cycle
module tb_traffic_phase_controller;
    typedef struct packed {
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        logic [1:0] ap;
        logic       fl;
    } snap_t;

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];
    snap_t obs, expv;

    traffic_phase_controller_if #(.NUM_PHASES(4)) bus ();

    traffic_phase_controller #(
        .NUM_PHASES(4), .GREEN_MIN(4), .GREEN_MAX(10), .YELLOW_T(3), .ALLRED_T(2), .FLASH_HALF(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // st: 0 green, 1 yellow, 2 all-red, 3 flash lit, 4 flash dark
    function automatic snap_t mk(int st, int ph);
        snap_t s;
        logic [3:0] oh;
        oh = 4'b0001 << ph;
        s = '0;
        s.ap = 2'(ph);
        if (st == 0) begin s.g = oh; s.r = ~oh; end
        if (st == 1) begin s.y = oh; s.r = ~oh; end
        if (st == 2) s.r = 4'hf;
        if (st == 3) begin s.y = 4'h1; s.r = 4'he; s.fl = 1'b1; s.ap = 2'd0; end
        if (st == 4) begin s.fl = 1'b1; s.ap = 2'd0; end
        return s;
    endfunction

    task automatic push(int st, int ph, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(st, ph));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.req = '0;
        bus.flash_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.req = 4'hf;
        bus.flash_en = 1'b1;
        push(0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL reset cyc %0d got %h exp %h", i, obs, expv); end
        end
    endtask

    task automatic test_rest();
        int n;
        do_reset();
        push(0, 0, 50);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL rest cyc %0d got %h exp %h", i, obs, expv); end
        end
    endtask

    task automatic test_min_green();
        int n;
        do_reset();
        push(0, 0, 4); push(1, 0, 3); push(2, 0, 2);
        push(0, 2, 4); push(1, 2, 3); push(2, 2, 2);
        push(0, 0, 12);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bus.req = {1'b0, i == 1, 1'b0, i == 9};
            obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL min_green cyc %0d got %h exp %h", i, obs, expv); end
        end
    endtask

    task automatic test_max_green();
        int n;
        do_reset();
        push(0, 0, 10); push(1, 0, 3); push(2, 0, 2);
        push(0, 1, 4); push(1, 1, 3); push(2, 1, 2);
        push(0, 0, 5);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bus.req = {2'b00, i <= 2, 1'b1};
            obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL max_green cyc %0d got %h exp %h", i, obs, expv); end
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        push(0, 0, 4); push(1, 0, 3); push(2, 0, 2);
        push(0, 2, 4); push(1, 2, 3); push(2, 2, 2);
        push(0, 3, 4); push(1, 3, 3); push(2, 3, 2);
        push(0, 1, 5);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bus.req = {i == 9, i == 1, i == 9, 1'b0};
            obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL round_robin cyc %0d got %h exp %h", i, obs, expv); end
        end
    endtask

    task automatic test_flash();
        int n;
        do_reset();
        push(0, 0, 2); push(1, 0, 3); push(2, 0, 2);
        push(3, 0, 5); push(4, 0, 5); push(3, 0, 5);
        push(2, 0, 2); push(0, 0, 5);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bus.flash_en = i >= 1 && i <= 20;
            obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL flash cyc %0d got %h exp %h", i, obs, expv); end
        end
    endtask

    task automatic test_reset_mid_yellow();
        int n;
        do_reset();
        push(0, 0, 4); push(1, 0, 2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bus.req = {1'b0, i == 1, 2'b00};
            obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL mid_yellow cyc %0d got %h exp %h", i, obs, expv); end
        end
        #2 reset_n = 1'b0;
        push(0, 0, 1);
        #1 obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL async_reset got %h exp %h", obs, expv); end
        @(negedge clk);
        reset_n = 1'b1;
        push(0, 0, 6);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            obs = {bus.green, bus.yellow, bus.red, bus.active_phase, bus.flashing};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL after_reset cyc %0d got %h exp %h", i, obs, expv); end
        end
    endtask

    initial begin
        bus.req = '0;
        bus.flash_en = 1'b0;
        test_reset();
        test_rest();
        test_min_green();
        test_max_green();
        test_round_robin();
        test_flash();
        test_reset_mid_yellow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end
endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 Parameter NUM_PHASES, default 4, SHALL set the number of signal phases (legal 2..8).
REQ-002 Parameter GREEN_MIN, default 8, SHALL set the minimum green duration in cycles (>=1).
REQ-003 Parameter GREEN_MAX, default 20, SHALL set the maximum green duration in cycles while another phase is pending (>=GREEN_MIN).
REQ-004 Parameter YELLOW_T, default 4, SHALL set the yellow duration in cycles (>=1).
REQ-005 Parameter ALLRED_T, default 2, SHALL set the all-red clearance duration in cycles (>=1).
REQ-006 Parameter FLASH_HALF, default 10, SHALL set the flash half-period in cycles (>=1).
REQ-007 Port clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-008 Port reset_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-009 Port req, input, NUM_PHASES, SHALL carry per-phase vehicle sensors (1 = vehicle present).
REQ-010 Port flash_en, input, 1, SHALL request flashing (night/fault) mode while high.
REQ-011 Ports green, yellow, red, output, NUM_PHASES each, SHALL drive per-phase lamps.
REQ-012 Port active_phase, output, clog2(NUM_PHASES), SHALL give the phase currently owning the right of way.
REQ-013 Port flashing, output, 1, SHALL be high exactly while the FSM is in FLASH.

Function
REQ-014 FSM states SHALL be GREEN, YELLOW, ALL_RED, FLASH; a timer SHALL clear to 0 on every state entry and increment each cycle in the state.
REQ-015 pend[i] SHALL set on any cycle req[i]=1 unless phase i is in GREEN, and SHALL clear on the cycle phase i enters GREEN; a set and a clear on the same cycle resolve to clear.
REQ-016 GREEN SHALL exit to YELLOW when some pend[j] (j != active_phase) is set and either (timer >= GREEN_MIN-1 and req[active_phase]=0) or timer = GREEN_MAX-1.
REQ-017 With no other phase pending, GREEN SHALL rest indefinitely and the timer SHALL saturate at GREEN_MAX-1.
REQ-018 YELLOW SHALL last exactly YELLOW_T cycles, then enter ALL_RED; ALL_RED SHALL last exactly ALLRED_T cycles.
REQ-019 On leaving ALL_RED (not flashing), the next phase SHALL be the first pending phase searched round-robin from active_phase+1 (mod NUM_PHASES); if none, phase 0.
REQ-020 flash_en=1 in GREEN SHALL force exit to YELLOW on the next edge regardless of GREEN_MIN; YELLOW and ALL_RED SHALL complete normally, then enter FLASH instead of GREEN.
REQ-021 In FLASH, phase 0 yellow and all other reds SHALL toggle every FLASH_HALF cycles, starting lit; all other lamps off.
REQ-022 flash_en=0 in FLASH SHALL enter ALL_RED on the next edge, then GREEN on phase 0 with pend unchanged.
REQ-023 Outside FLASH, each phase SHALL have exactly one lamp lit: active phase green in GREEN, yellow in YELLOW, red otherwise; all non-active phases red.
REQ-024 Lamp outputs SHALL be decoded from registered state only (no combinational path from req or flash_en).

Reset
REQ-025 While reset_n=0: state GREEN, active_phase 0, timer 0, pend 0, flashing 0, green=1 on phase 0 only, red on all others, yellow all 0.
REQ-026 Reset asserted mid-YELLOW, mid-ALL_RED or mid-FLASH SHALL take effect immediately and abandon the sequence; release SHALL resume from the REQ-025 state on the first rising edge.

Verification (NUM_PHASES=4, GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=3, ALLRED_T=2, FLASH_HALF=5)
REQ-027 Release reset, req=0 for 50 cycles -> phase 0 green throughout, red on phases 1-3, pend=0.
REQ-028 req[2]=1 pulse for 1 cycle at cycle 1, req[0]=0 -> green 4 cycles, yellow 3, all-red 2, phase 2 green; pend[2] clears on entry.
REQ-029 req[0] held 1 and req[1]=1 -> phase 0 green exactly 10 cycles (max-out), then yellow 3, all-red 2, phase 1 green.
REQ-030 pend[1] and pend[3] set while phase 2 green -> order 2, 3, 1 (round-robin wrap).
REQ-031 flash_en=1 at green timer 1 -> yellow next edge, 3 yellow, 2 all-red, FLASH: phase 0 yellow 5 on / 5 off, phases 1-3 red in step; flash_en=0 -> 2 all-red then phase 0 green.
REQ-032 reset_n=0 during second yellow cycle -> outputs per REQ-025 without waiting for a clock edge.
